// File: rtl/phy_tx_pkg.sv
// Shared types and constants for the single-clock PHY Tx lane serializer.
package phy_tx_pkg;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } link_state_e;

  // K28.5 comma, sent whenever nothing is being transmitted
  localparam logic [7:0] IDLE_K285 = 8'hBC;

  // Ceiling log2, never below 1 so counters always have at least one bit
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/phy_tx_lane_serializer_if.sv
// Lane bundle handshake between the frame source and the serializer.
interface phy_tx_lane_serializer_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8
);

  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       in_valid;
  logic                   in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/phy_tx_frame_shift.sv
// Frame-wide shift register; loads lane 0 into the top bits so it leaves first,
// replacing idle or invalid lanes with the IDLE symbol.
module phy_tx_frame_shift
  import phy_tx_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter logic [7:0]  IDLE_SYM = IDLE_K285
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   idle_all,
  input  logic [LANES*WIDTH-1:0] data,
  input  logic [LANES-1:0]       valid,
  output logic                   serial
);

  localparam int unsigned FRAME = LANES * WIDTH;
  localparam logic [WIDTH-1:0] IDLE_W = WIDTH'(IDLE_SYM);

  logic [FRAME-1:0] sh;
  logic [FRAME-1:0] load_word_c;

  always_comb begin
    load_word_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      load_word_c[FRAME-1-i*WIDTH -: WIDTH] =
        (!idle_all && valid[i]) ? data[i*WIDTH +: WIDTH] : IDLE_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (load) begin
      sh <= load_word_c;
    end else begin
      sh <= {sh[FRAME-2:0], 1'b0};
    end
  end

  assign serial = sh[FRAME-1];

endmodule

// File: rtl/phy_tx_lane_serializer.sv
// Single-clock PHY Tx: frame counter, TRAIN/ACTIVE link FSM, recirculation
// to the tester port and MSB-first serialisation of the lane bundle.
module phy_tx_lane_serializer
  import phy_tx_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned WIDTH      = 8,
  parameter logic [7:0]  IDLE_SYM   = IDLE_K285,
  parameter int unsigned ACT_FRAMES = 2
) (
  input  logic                      clk32f,
  input  logic                      reset,
  phy_tx_lane_serializer_if.slave   bus,
  input  logic                      rx_active,
  output logic                      out_serial,
  output logic                      out_sync,
  output logic                      link_active,
  output logic [LANES*WIDTH-1:0]    recir_data,
  output logic [LANES-1:0]          recir_valid
);

  localparam int unsigned FRAME = LANES * WIDTH;
  localparam int unsigned CNT_W = clog2(FRAME);
  localparam int unsigned ACT_W = clog2(ACT_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME - 1);
  localparam logic [ACT_W-1:0] ACT_MAX = ACT_W'(ACT_FRAMES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next_c;
  logic [ACT_W-1:0] act_cnt;
  logic [ACT_W-1:0] act_next_c;
  link_state_e      state;
  link_state_e      state_next_c;
  logic             boundary_c;
  logic             handshake_c;
  logic             load_idle_c;
  logic             ready_q;

  // Next counter, activity and link state as they will be after this edge
  always_comb begin
    boundary_c   = (cnt == LAST);
    cnt_next_c   = boundary_c ? '0 : cnt + 1'b1;
    act_next_c   = '0;
    state_next_c = state;
    if (rx_active) begin
      act_next_c = (act_cnt == ACT_MAX) ? ACT_MAX : act_cnt + 1'b1;
    end
    if (!rx_active) begin
      state_next_c = TRAIN;
    end else if (act_next_c == ACT_MAX) begin
      state_next_c = ACTIVE;
    end
    handshake_c = |bus.in_valid;
    load_idle_c = (state_next_c == TRAIN);
  end

  // in_ready and out_sync are precomputed from the next count so they stay flops
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      act_cnt     <= '0;
      state       <= TRAIN;
      ready_q     <= 1'b0;
      out_sync    <= 1'b1;
      link_active <= 1'b0;
      recir_data  <= '0;
      recir_valid <= '0;
    end else begin
      cnt      <= cnt_next_c;
      ready_q  <= (cnt_next_c == LAST);
      out_sync <= (cnt_next_c == '0);
      if (boundary_c) begin
        act_cnt     <= act_next_c;
        state       <= state_next_c;
        link_active <= (state_next_c == ACTIVE);
        if (load_idle_c && handshake_c) begin
          recir_data  <= bus.in_data;
          recir_valid <= bus.in_valid;
        end else begin
          recir_valid <= '0;
        end
      end
    end
  end

  assign bus.in_ready = ready_q;

  phy_tx_frame_shift #(
    .LANES    (LANES),
    .WIDTH    (WIDTH),
    .IDLE_SYM (IDLE_SYM)
  ) u_shift (
    .clk      (clk32f),
    .rst_n    (reset),
    .load     (boundary_c),
    .idle_all (load_idle_c),
    .data     (bus.in_data),
    .valid    (bus.in_valid),
    .serial   (out_serial)
  );

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Directed plus randomized bench for phy_tx_lane_serializer in three lane/width
// configurations, checked against a frame-level model of the link rules.
module tb_phy_tx_lane_serializer;

  localparam int unsigned AF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic        rx;
  logic [63:0] din;
  logic [7:0]  vl;

  logic        ser  [3];
  logic        syn  [3];
  logic        lnk  [3];
  logic        rdy  [3];
  logic [63:0] rdat [3];
  logic [7:0]  rval [3];

  logic [31:0] rd_a;
  logic [19:0] rd_b;
  logic [63:0] rd_c;
  logic [3:0]  rv_a;
  logic [1:0]  rv_b;
  logic [7:0]  rv_c;

  phy_tx_lane_serializer_if #(.LANES(4), .WIDTH(8))  bus_a ();
  phy_tx_lane_serializer_if #(.LANES(2), .WIDTH(10)) bus_b ();
  phy_tx_lane_serializer_if #(.LANES(8), .WIDTH(8))  bus_c ();

  assign bus_a.in_data  = din[31:0];
  assign bus_a.in_valid = vl[3:0];
  assign bus_b.in_data  = din[19:0];
  assign bus_b.in_valid = vl[1:0];
  assign bus_c.in_data  = din;
  assign bus_c.in_valid = vl;

  assign rdy[0]  = bus_a.in_ready;
  assign rdy[1]  = bus_b.in_ready;
  assign rdy[2]  = bus_c.in_ready;
  assign rdat[0] = 64'(rd_a);
  assign rdat[1] = 64'(rd_b);
  assign rdat[2] = rd_c;
  assign rval[0] = 8'(rv_a);
  assign rval[1] = 8'(rv_b);
  assign rval[2] = rv_c;

  phy_tx_lane_serializer #(.LANES(4), .WIDTH(8), .IDLE_SYM(8'hBC), .ACT_FRAMES(AF)) dut_a (
    .clk32f(clk), .reset(rst[0]), .bus(bus_a.slave), .rx_active(rx),
    .out_serial(ser[0]), .out_sync(syn[0]), .link_active(lnk[0]),
    .recir_data(rd_a), .recir_valid(rv_a));

  phy_tx_lane_serializer #(.LANES(2), .WIDTH(10), .IDLE_SYM(8'hBC), .ACT_FRAMES(AF)) dut_b (
    .clk32f(clk), .reset(rst[1]), .bus(bus_b.slave), .rx_active(rx),
    .out_serial(ser[1]), .out_sync(syn[1]), .link_active(lnk[1]),
    .recir_data(rd_b), .recir_valid(rv_b));

  phy_tx_lane_serializer #(.LANES(8), .WIDTH(8), .IDLE_SYM(8'hBC), .ACT_FRAMES(AF)) dut_c (
    .clk32f(clk), .reset(rst[2]), .bus(bus_c.slave), .rx_active(rx),
    .out_serial(ser[2]), .out_sync(syn[2]), .link_active(lnk[2]),
    .recir_data(rd_c), .recir_valid(rv_c));

  int unsigned fl [3] = '{32, 20, 64};
  int unsigned ln [3] = '{4, 2, 8};
  int unsigned wd [3] = '{8, 10, 8};

  int          cur;
  logic [63:0] exp_bits;
  logic [63:0] m_rd;
  logic [7:0]  m_rv;
  int unsigned m_act;
  bit          m_on;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s (dut %0d): got %0h, expected %0h", tag, cur, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_bits = '0;
    m_rd     = '0;
    m_rv     = '0;
    m_act    = 0;
    m_on     = 1'b0;
  endtask

  // Called at posedge+1; holds every DUT in reset, then releases only dut d
  task automatic start_dut(input int d);
    rst = 3'b000;
    #2;
    rst = 3'(1 << d);
    cur = d;
    model_reset();
  endtask

  // Model of one boundary: link state after it, frame to send, recirculation
  task automatic model_boundary(input bit r, input logic [63:0] data, input logic [7:0] v);
    int unsigned L, W;
    logic [63:0] wm, fm, word, idle;
    logic [7:0]  lm;
    bit          nxt;
    L    = ln[cur];
    W    = wd[cur];
    wm   = (64'd1 << W) - 64'd1;
    fm   = (64'd1 << (L * W)) - 64'd1;
    lm   = 8'((16'd1 << L) - 16'd1);
    idle = 64'hBC & wm;
    m_act = r ? ((m_act < AF) ? m_act + 1 : AF) : 0;
    nxt   = m_on ? r : (m_act == AF);
    exp_bits = '0;
    for (int unsigned i = 0; i < L; i++) begin
      word = (nxt && v[i]) ? ((data >> (i * W)) & wm) : idle;
      for (int unsigned j = 0; j < W; j++) exp_bits[i*W+j] = word[W-1-j];
    end
    if (!nxt && ((v & lm) != 8'd0)) begin
      m_rd = data & fm;
      m_rv = v & lm;
    end else begin
      m_rv = '0;
    end
    m_on = nxt;
  endtask

  // Observe the current frame from cnt==0, then drive and check one boundary
  task automatic frame(input bit r, input logic [63:0] data, input logic [7:0] v);
    logic [63:0] gs, gy, gr;
    int unsigned F;
    F  = fl[cur];
    gs = '0;
    gy = '0;
    gr = '0;
    for (int unsigned k = 0; k < F; k++) begin
      gs[k] = ser[cur];
      gy[k] = syn[cur];
      gr[k] = rdy[cur];
      if (k != F - 1) begin
        @(posedge clk);
        #1;
      end
    end
    chk("serial_bits", gs, exp_bits);
    chk("sync_pos", gy, 64'd1);
    chk("ready_pos", gr, 64'd1 << (F - 1));
    rx  = r;
    din = data;
    vl  = v;
    model_boundary(r, data, v);
    @(posedge clk);
    #1;
    chk("link_active", 64'(lnk[cur]), 64'(m_on));
    chk("recir_valid", 64'(rval[cur]), 64'(m_rv));
    chk("recir_data", rdat[cur], m_rd);
  endtask

  task automatic rand_frame(input bit mostly_on);
    bit r;
    r = mostly_on ? ($urandom_range(3) != 0) : ($urandom_range(1) != 0);
    frame(r, {$urandom, $urandom}, 8'($urandom));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cur    = 0;
    rst    = 3'b000;
    rx     = 1'b0;
    din    = '0;
    vl     = '0;
    model_reset();

    #21;
    chk("rst_serial", 64'(ser[0]), 64'd0);
    chk("rst_sync", 64'(syn[0]), 64'd1);
    chk("rst_ready", 64'(rdy[0]), 64'd0);
    chk("rst_link", 64'(lnk[0]), 64'd0);
    chk("rst_recir_valid", 64'(rval[0]), 64'd0);
    chk("rst_recir_data", rdat[0], 64'd0);
    start_dut(0);

    // Training: everything goes out as IDLE, handshakes are recirculated
    frame(1'b0, 64'hDEADBEEF, 8'h0F);
    frame(1'b0, 64'h12345678, 8'h00);
    frame(1'b0, 64'hCAFEF00D, 8'h03);
    frame(1'b0, 64'h0, 8'h00);

    // Link comes up after two active boundaries
    frame(1'b1, 64'h0, 8'h00);
    frame(1'b1, 64'h0, 8'h00);
    frame(1'b1, 64'h44332211, 8'h0F);
    frame(1'b1, 64'hAABBCCDD, 8'h05);
    frame(1'b0, 64'h01020304, 8'h0F);
    frame(1'b0, 64'h0, 8'h00);
    for (int i = 0; i < 12; i++) rand_frame(1'b1);

    // Reset in the middle of an active frame
    frame(1'b1, 64'h0, 8'h0F);
    frame(1'b1, 64'h0, 8'h0F);
    frame(1'b1, 64'h55667788, 8'h0F);
    repeat (13) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    #1;
    chk("midrst_serial", 64'(ser[0]), 64'd0);
    chk("midrst_link", 64'(lnk[0]), 64'd0);
    chk("midrst_recir_valid", 64'(rval[0]), 64'd0);
    chk("midrst_sync", 64'(syn[0]), 64'd1);
    #2;
    rst[0] = 1'b1;
    model_reset();
    frame(1'b1, 64'h99AABBCC, 8'h0F);
    frame(1'b1, 64'h11223344, 8'h0F);
    frame(1'b1, 64'h0, 8'h00);

    // Other lane/width configurations
    start_dut(1);
    for (int i = 0; i < 10; i++) rand_frame(1'b1);
    frame(1'b1, 64'h0, 8'h00);
    start_dut(2);
    for (int i = 0; i < 10; i++) rand_frame(1'b1);
    frame(1'b1, 64'h0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
